// File: rtl/env_detect_ma.sv
// Envelope detector: full-wave rectify with saturation, then a 2^LOG2_WIN-tap boxcar average.
// One unsigned envelope sample per accepted input; 'clear' restarts the filter per scan line.
module env_detect_ma #(
  parameter int unsigned IN_WIDTH  = 20,
  parameter int unsigned LOG2_WIN  = 3,
  parameter int unsigned OUT_WIDTH = IN_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_primed,
  output logic [1:0]           debug_state
);

  localparam int unsigned WIN = 1 << LOG2_WIN;
  localparam int unsigned CW  = LOG2_WIN + 1;
  localparam int unsigned SW  = OUT_WIDTH + LOG2_WIN;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LOG2_WIN-1:0]  wptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        sum;
  logic [SW-1:0]        sum_nxt;
  logic [OUT_WIDTH-1:0] win_buf [WIN];
  logic [OUT_WIDTH-1:0] rect;
  logic [OUT_WIDTH-1:0] old;
  logic                 accept;

  assign in_ready    = (state == ST_FILL || state == ST_RUN) && !clear && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready && reset;
  assign debug_state = state;
  assign old         = win_buf[wptr];
  assign sum_nxt     = sum + SW'(rect) - SW'(old);

  // Absolute value; the most negative input has no positive twin and saturates.
  always_comb begin
    rect = in_data[OUT_WIDTH-1:0];
    if (in_data[IN_WIDTH-1]) begin
      if (in_data == {1'b1, {(IN_WIDTH-1){1'b0}}}) rect = {OUT_WIDTH{1'b1}};
      else                                          rect = OUT_WIDTH'(-in_data);
    end
  end

  // Next-state logic; clear wins over every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (wptr == LOG2_WIN'(WIN - 1)) state_nxt = ST_FILL;
      ST_FILL:  if (accept && count == CW'(WIN - 1)) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
    if (clear) state_nxt = ST_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      wptr       <= '0;
      count      <= '0;
      sum        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        wptr      <= '0;
        count     <= '0;
        sum       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (state == ST_CLEAR) wptr <= wptr + 1'b1;
        if (accept) begin
          wptr       <= wptr + 1'b1;
          sum        <= sum_nxt;
          out_data   <= OUT_WIDTH'(sum_nxt >> LOG2_WIN);
          out_valid  <= 1'b1;
          out_primed <= (CW'(count + 1'b1) >= CW'(WIN));
          if (count != CW'(WIN)) count <= count + 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Window storage: zeroed slot by slot during CLEAR, overwritten oldest-first on accept.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) win_buf[wptr] <= '0;
    else if (accept)       win_buf[wptr] <= rect;
  end

endmodule

// File: tb/tb_env_detect_ma.sv
// Directed bench for env_detect_ma (WIN=4): scoreboard of expected envelope samples plus
// directed checks of reset, clear sequencing, back-pressure and saturation.
module tb_env_detect_ma;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [19:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_data;
  logic        out_primed;
  logic [1:0]  debug_state;

  typedef struct {
    logic [18:0] data;
    logic        primed;
  } exp_t;

  exp_t        exp_q[$];
  int          hist[$];
  int          nacc;
  int          checks;
  int          errors;
  logic [18:0] last_data;

  env_detect_ma #(.IN_WIDTH(20), .LOG2_WIN(2)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_primed(out_primed), .debug_state(debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    nacc = 0;
  endtask

  // Reference: average of the last up-to-4 rectified samples since the last restart.
  task automatic model_push(input int v);
    int   r;
    int   s;
    exp_t e;
    r = (v < 0) ? ((v == -524288) ? 524287 : -v) : v;
    hist.push_back(r);
    if (hist.size() > 4) void'(hist.pop_front());
    s = 0;
    foreach (hist[i]) s += hist[i];
    nacc++;
    e.data    = 19'(s / 4);
    e.primed  = (nacc >= 4);
    last_data = e.data;
    exp_q.push_back(e);
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int v);
    int n;
    in_valid = 1'b1;
    in_data  = 20'(v);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", in_ready, 1);
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      return;
    end
    model_push(v);
    step();
    chk("latency_valid", out_valid, 1);
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      chk({tag, "_out_valid"}, out_valid, 0);
      n++;
      step();
    end
    chk({tag, "_len"}, n, 4);
    chk({tag, "_state_fill"}, debug_state, 1);
  endtask

  // Scoreboard: every completed output transfer pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed extra output %0d expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_primed", out_primed, e.primed);
      end
    end
  end

  initial begin
    int d2[5];
    int p2[5];
    logic [18:0] held;
    d2 = '{25, 75, 150, 250, 227};
    p2 = '{0, 0, 0, 1, 1};
    checks = 0;
    errors = 0;
    model_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_primed", out_primed, 0);
    chk("rst_state", debug_state, 0);
    chk("rst_in_ready", in_ready, 0);

    // Reset release: four CLEAR cycles, then FILL.
    reset = 1'b1;
    count_clear("init_clear");

    // Back-to-back warm-up and steady state.
    send(100);  chk("t2_data0", out_data, d2[0]); chk("t2_primed0", out_primed, p2[0]);
    send(-200); chk("t2_data1", out_data, d2[1]); chk("t2_primed1", out_primed, p2[1]);
    send(300);  chk("t2_data2", out_data, d2[2]); chk("t2_primed2", out_primed, p2[2]);
    send(-400); chk("t2_data3", out_data, d2[3]); chk("t2_primed3", out_primed, p2[3]);
    chk("t2_state_run", debug_state, 2);
    send(8);    chk("t2_data4", out_data, d2[4]); chk("t2_primed4", out_primed, p2[4]);

    // Most negative input saturates; the sum must not wrap.
    repeat (4) send(-524288);
    chk("t3_sat_data", out_data, 524287);
    chk("t3_sat_primed", out_primed, 1);
    in_valid = 1'b0;
    step();
    chk("t3_drained", out_valid, 0);

    // Back-pressure: output held, input stalled, then everything drains in order.
    send(1000);
    held = last_data;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 20'(-3000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_in_ready", in_ready, 0);
      chk("t4_valid", out_valid, 1);
      chk("t4_held", out_data, held);
    end
    out_ready = 1'b1;
    send(-3000);
    send(77);
    send(-5);
    in_valid = 1'b0;
    repeat (2) step();
    chk("t4_sb_empty", exp_q.size(), 0);

    // Clear with a stalled output: output discarded, filter restarts from zero.
    send(12345);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b1;
    model_reset();
    #1;
    chk("t5_in_ready_clr", in_ready, 0);
    step();
    clear = 1'b0;
    chk("t5_discard", out_valid, 0);
    out_ready = 1'b1;
    count_clear("t5_clear");
    step();
    send(40);
    chk("t5_data", out_data, 10);
    chk("t5_primed", out_primed, 0);

    // Reset mid-RUN with a sample offered: not accepted, outputs zeroed, CLEAR restarts.
    send(4);
    send(8);
    send(12);
    chk("t6_state_run", debug_state, 2);
    in_valid = 1'b1;
    in_data  = 20'(777);
    reset    = 1'b0;
    model_reset();
    step();
    reset    = 1'b1;
    in_valid = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_primed", out_primed, 0);
    chk("t6_state", debug_state, 0);
    count_clear("t6_clear");
    step();
    send(16);
    chk("t6_fresh_data", out_data, 4);
    chk("t6_fresh_primed", out_primed, 0);
    in_valid = 1'b0;
    repeat (3) step();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
